// File: rtl/counter_sweep_ctrl.sv
// Sweep controller for an external up/down counter.
// Drives the counter back and forth between two latched limits with optional dwell.
module counter_sweep_ctrl #(
   parameter int WIDTH = 7,
   parameter int CW    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] lo_lim,
   input  logic [WIDTH-1:0] hi_lim,
   input  logic [CW-1:0]    dwell,
   input  logic [CW-1:0]    sweeps,
   input  logic [WIDTH-1:0] cnt_value,
   output logic             cnt_enable,
   output logic             cnt_dir,
   output logic             busy,
   output logic [2:0]       state,
   output logic [CW-1:0]    sweep_cnt,
   output logic             done,
   output logic             cfg_err
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SEEK     = 3'd1,
      UP       = 3'd2,
      DWELL_HI = 3'd3,
      DOWN     = 3'd4,
      DWELL_LO = 3'd5
   } st_t;

   st_t             st;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic [CW-1:0]    dw;
   logic [CW-1:0]    nsw;
   logic [CW-1:0]    dcnt;
   logic [WIDTH-1:0] nxt;
   logic             last_sweep;

   // value the counter takes at the coming edge
   assign nxt = !cnt_enable ? cnt_value :
                cnt_dir     ? cnt_value + WIDTH'(1) :
                              cnt_value - WIDTH'(1);

   assign last_sweep = (nsw != '0) && (sweep_cnt + CW'(1) == nsw);
   assign state = st;

   always_ff @(posedge clk) begin
      if (rst) begin
         st         <= IDLE;
         cnt_enable <= 1'b0;
         cnt_dir    <= 1'b0;
         busy       <= 1'b0;
         sweep_cnt  <= '0;
         done       <= 1'b0;
         cfg_err    <= 1'b0;
         lo         <= '0;
         hi         <= '0;
         dw         <= '0;
         nsw        <= '0;
         dcnt       <= '0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            st         <= IDLE;
            cnt_enable <= 1'b0;
            busy       <= 1'b0;
         end else begin
            case (st)
               IDLE: begin
                  if (start) begin
                     if (hi_lim > lo_lim) begin
                        lo        <= lo_lim;
                        hi        <= hi_lim;
                        dw        <= dwell;
                        nsw       <= sweeps;
                        sweep_cnt <= '0;
                        cfg_err   <= 1'b0;
                        busy      <= 1'b1;
                        st        <= SEEK;
                     end else begin
                        cfg_err <= 1'b1;
                     end
                  end
               end
               SEEK: begin
                  if (nxt == lo) begin
                     st <= UP;
                     // arriving from above: pause one cycle before turning
                     if (cnt_enable && !cnt_dir) begin
                        cnt_enable <= 1'b0;
                     end else begin
                        cnt_enable <= 1'b1;
                        cnt_dir    <= 1'b1;
                     end
                  end else if (!cnt_enable) begin
                     cnt_enable <= 1'b1;
                     cnt_dir    <= (cnt_value < lo);
                  end
               end
               UP: begin
                  if (cnt_enable && cnt_dir && cnt_value == hi - WIDTH'(1)) begin
                     if (dw == '0) begin
                        st      <= DOWN;
                        cnt_dir <= 1'b0;
                     end else begin
                        st         <= DWELL_HI;
                        cnt_enable <= 1'b0;
                        dcnt       <= dw;
                     end
                  end else begin
                     cnt_enable <= 1'b1;
                     cnt_dir    <= 1'b1;
                  end
               end
               DWELL_HI: begin
                  if (dcnt <= CW'(1)) begin
                     st         <= DOWN;
                     cnt_enable <= 1'b1;
                     cnt_dir    <= 1'b0;
                  end else begin
                     dcnt <= dcnt - CW'(1);
                  end
               end
               DOWN: begin
                  if (cnt_enable && !cnt_dir && cnt_value == lo + WIDTH'(1)) begin
                     sweep_cnt <= sweep_cnt + CW'(1);
                     if (last_sweep) begin
                        st         <= IDLE;
                        busy       <= 1'b0;
                        cnt_enable <= 1'b0;
                        done       <= 1'b1;
                     end else if (dw != '0) begin
                        st         <= DWELL_LO;
                        cnt_enable <= 1'b0;
                        dcnt       <= dw;
                     end else begin
                        st      <= UP;
                        cnt_dir <= 1'b1;
                     end
                  end else begin
                     cnt_enable <= 1'b1;
                     cnt_dir    <= 1'b0;
                  end
               end
               DWELL_LO: begin
                  if (dcnt <= CW'(1)) begin
                     st         <= UP;
                     cnt_enable <= 1'b1;
                     cnt_dir    <= 1'b1;
                  end else begin
                     dcnt <= dcnt - CW'(1);
                  end
               end
               default: begin
                  st         <= IDLE;
                  busy       <= 1'b0;
                  cnt_enable <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: external counter model plus a trace-based
// reference that lists the expected per-cycle outputs of a whole run.
module tb_counter_sweep_ctrl;
   localparam int W = 7;
   localparam int C = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic [W-1:0] lo_lim = '0;
   logic [W-1:0] hi_lim = '0;
   logic [C-1:0] dwell = '0;
   logic [C-1:0] sweeps = '0;
   logic [W-1:0] cnt = '0;
   logic         cnt_enable, cnt_dir, busy, done, cfg_err;
   logic [2:0]   state;
   logic [C-1:0] sweep_cnt;
   logic         ld = 1'b0;
   logic [W-1:0] ld_val = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   counter_sweep_ctrl #(.WIDTH(W), .CW(C)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .lo_lim(lo_lim), .hi_lim(hi_lim), .dwell(dwell), .sweeps(sweeps),
      .cnt_value(cnt), .cnt_enable(cnt_enable), .cnt_dir(cnt_dir),
      .busy(busy), .state(state), .sweep_cnt(sweep_cnt),
      .done(done), .cfg_err(cfg_err)
   );

   // the controlled counter
   always @(posedge clk) begin
      if (ld) cnt <= ld_val;
      else if (cnt_enable === 1'b1) cnt <= cnt_dir ? cnt + 7'd1 : cnt - 7'd1;
   end

   typedef struct {
      logic [2:0] st;
      logic       en, dir, busy, done, err;
      logic [7:0] swc;
      logic [6:0] cnt;
   } rec_t;

   rec_t       e;
   bit         chk = 0;
   rec_t       tr[$];
   logic [6:0] hist[$];
   int         done_n, done_idx;

   logic       m_dir = 0;
   logic [7:0] m_swc = 0;
   logic       m_err = 0;
   logic [6:0] m_cnt = 0;

   task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, a, x, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk) begin
         cmp("state", 32'(state), 32'(e.st));
         cmp("cnt_enable", 32'(cnt_enable), 32'(e.en));
         cmp("cnt_dir", 32'(cnt_dir), 32'(e.dir));
         cmp("busy", 32'(busy), 32'(e.busy));
         cmp("done", 32'(done), 32'(e.done));
         cmp("cfg_err", 32'(cfg_err), 32'(e.err));
         cmp("sweep_cnt", 32'(sweep_cnt), 32'(e.swc));
         cmp("cnt_value", 32'(cnt), 32'(e.cnt));
      end
   end

   function automatic rec_t mk(int st, int en, int dir, int swc, int cv, int dn);
      rec_t r;
      r.st = 3'(st); r.en = 1'(en); r.dir = 1'(dir);
      r.busy = (st != 0); r.done = 1'(dn); r.err = 1'b0;
      r.swc = 8'(swc); r.cnt = 7'(cv);
      return r;
   endfunction

   function automatic rec_t idle_rec();
      rec_t r = mk(0, 0, int'(m_dir), int'(m_swc), int'(m_cnt), 0);
      r.err = m_err;
      return r;
   endfunction

   // expected outputs of a whole run, one entry per cycle after the start edge
   function automatic void build(int c0, int lo, int hi, int dw, int sw, int d0);
      int k = 0;
      tr = {};
      tr.push_back(mk(1, 0, d0, 0, c0, 0));
      if (c0 < lo) begin
         for (int v = c0; v < lo; v++) tr.push_back(mk(1, 1, 1, 0, v, 0));
      end else if (c0 > lo) begin
         for (int v = c0; v > lo; v--) tr.push_back(mk(1, 1, 0, 0, v, 0));
         tr.push_back(mk(2, 0, 0, 0, lo, 0));
      end
      while (tr.size() < 2000) begin
         for (int v = lo; v < hi; v++) tr.push_back(mk(2, 1, 1, k, v, 0));
         for (int i = 0; i < dw; i++) tr.push_back(mk(3, 0, 1, k, hi, 0));
         for (int v = hi; v > lo; v--) tr.push_back(mk(4, 1, 0, k, v, 0));
         k = (k + 1) % 256;
         if (sw != 0 && k == sw) begin
            tr.push_back(mk(0, 0, 0, k, lo, 1));
            return;
         end
         for (int i = 0; i < dw; i++) tr.push_back(mk(5, 0, 0, k, lo, 0));
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int c0, input int lo, input int hi, input int dw,
                      input int sw, input int stop_st, input int stop_at,
                      input int rst_st, input int rst_at);
      int sa = stop_at;
      int ra = rst_at;
      rec_t last;
      ld = 1'b1; ld_val = 7'(c0);
      tick();
      ld = 1'b0; m_cnt = 7'(c0); e = idle_rec();
      lo_lim = 7'(lo); hi_lim = 7'(hi); dwell = 8'(dw); sweeps = 8'(sw);
      start = 1'b1;
      tick();
      start = 1'b0;
      hist = {}; done_n = 0; done_idx = -1;
      if (hi <= lo) begin
         m_err = 1'b1; e = idle_rec();
         repeat (3) tick();
         return;
      end
      m_err = 1'b0;
      build(c0, lo, hi, dw, sw, int'(m_dir));
      if (stop_st >= 0)
         while (sa < tr.size() && int'(tr[sa].st) != stop_st) sa++;
      if (rst_st >= 0)
         while (ra < tr.size() && int'(tr[ra].st) != rst_st) ra++;
      if (sw == 0 && (sa < 0 || sa >= tr.size()) && (ra < 0 || ra >= tr.size()))
         sa = tr.size() - 1;
      for (int j = 0; j < tr.size(); j++) begin
         e = tr[j];
         hist.push_back(cnt);
         if (done === 1'b1) begin
            done_n++;
            if (done_idx < 0) done_idx = j;
         end
         if (tr[j].st == 3'd0) break;
         lo_lim = 7'($urandom); hi_lim = 7'($urandom);
         dwell = 8'($urandom); sweeps = 8'($urandom);
         start = 1'($urandom);
         if (j == sa) stop = 1'b1;
         if (j == ra) rst = 1'b1;
         tick();
         if (stop || rst) begin
            m_cnt = tr[j].en ? (tr[j].dir ? tr[j].cnt + 7'd1 : tr[j].cnt - 7'd1)
                             : tr[j].cnt;
            if (rst) begin
               m_dir = 1'b0; m_swc = '0; m_err = 1'b0;
            end else begin
               m_dir = tr[j].dir; m_swc = tr[j].swc;
            end
            stop = 1'b0; rst = 1'b0; start = 1'b0;
            e = idle_rec();
            tick(); tick();
            return;
         end
      end
      start = 1'b0;
      last = tr[tr.size()-1];
      m_cnt = last.cnt; m_dir = last.dir; m_swc = last.swc;
      tick();
      e = idle_rec();
      tick();
   endtask

   int exp36[12] = '{0, 0, 1, 2, 3, 4, 5, 5, 5, 4, 3, 2};
   int exp37[8]  = '{3, 3, 4, 3, 4, 3, 4, 3};

   task automatic check_hist36(input string n);
      cmp({n, "_len"}, 32'(hist.size()), 32'd12);
      for (int i = 0; i < 12 && i < hist.size(); i++)
         cmp({n, "_cnt"}, 32'(hist[i]), 32'(exp36[i]));
      cmp({n, "_done_n"}, 32'(done_n), 32'd1);
      cmp({n, "_swc"}, 32'(sweep_cnt), 32'd1);
      tick(); tick();
      cmp({n, "_hold"}, 32'(cnt), 32'd2);
   endtask

   initial begin
      int mx, mn, seen, lo, hi, c0, dw, sw, sa, ra;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      e = idle_rec();
      chk = 1;
      cmp("reset_busy", 32'(busy), 32'd0);
      cmp("reset_state", 32'(state), 32'd0);
      tick();

      // basic sweep with dwell
      run(0, 2, 5, 2, 1, -1, -1, -1, -1);
      check_hist36("sweep36");

      // tight limits, no dwell, three sweeps
      run(3, 3, 4, 0, 3, -1, -1, -1, -1);
      cmp("sweep37_len", 32'(hist.size()), 32'd8);
      for (int i = 0; i < 8 && i < hist.size(); i++)
         cmp("sweep37_cnt", 32'(hist[i]), 32'(exp37[i]));
      cmp("sweep37_done_idx", 32'(done_idx), 32'd7);

      // seek down from far above
      run(100, 10, 20, 1, 1, -1, -1, -1, -1);
      cmp("seek38_len", 32'(hist.size()), 32'd114);
      mx = 0; mn = 127; seen = 0;
      foreach (hist[i]) begin
         if (hist[i] == 7'd10) seen = 1;
         if (seen != 0) begin
            if (hist[i] > mx) mx = hist[i];
            if (hist[i] < mn) mn = hist[i];
         end
      end
      cmp("seek38_max", 32'(mx), 32'd20);
      cmp("seek38_min", 32'(mn), 32'd10);

      // rejected configuration
      run(8, 8, 8, 1, 1, -1, -1, -1, -1);
      cmp("cfg39_err", 32'(cfg_err), 32'd1);
      cmp("cfg39_busy", 32'(busy), 32'd0);

      // start together with stop in IDLE resolves as stop
      lo_lim = 7'd2; hi_lim = 7'd5; start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      tick();
      cmp("startstop_busy", 32'(busy), 32'd0);

      // continuous run stopped while sweeping up
      run(5, 4, 9, 1, 0, 2, 20, -1, -1);
      cmp("stop40_state", 32'(state), 32'd0);
      mx = cnt;
      tick(); tick();
      cmp("stop40_frozen", 32'(cnt), 32'(mx));

      // continuous run long enough for sweep_cnt to wrap
      run(3, 3, 4, 0, 0, -1, 600, -1, -1);
      cmp("wrap_swc", 32'(sweep_cnt), 32'd43);
      cmp("wrap_cnt", 32'(cnt), 32'd3);

      // reset mid-run while sweeping down, then a cold-style run
      run(0, 1, 6, 0, 2, -1, -1, 4, 10);
      cmp("rst41_state", 32'(state), 32'd0);
      cmp("rst41_swc", 32'(sweep_cnt), 32'd0);
      run(0, 2, 5, 2, 1, -1, -1, -1, -1);
      check_hist36("cold41");

      // randomized runs
      for (int r = 0; r < 25; r++) begin
         c0 = $urandom_range(0, 127);
         lo = $urandom_range(0, 126);
         if ($urandom_range(0, 5) == 0) hi = $urandom_range(0, lo);
         else hi = lo + $urandom_range(1, (127 - lo < 12) ? 127 - lo : 12);
         dw = $urandom_range(0, 3);
         sw = $urandom_range(0, 3);
         sa = -1; ra = -1;
         if (sw == 0 || $urandom_range(0, 3) == 0) sa = $urandom_range(0, 150);
         if ($urandom_range(0, 5) == 0) ra = $urandom_range(0, 100);
         run(c0, lo, hi, dw, sw, -1, sa, -1, ra);
      end

      chk = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
